usb_data_buffer: RTL and testbench

//  Shared byte FIFO between the AHB slave and the USB TX/RX datapaths. Directly upstream of usb_tx:
//  - sources tx_packet_data and buffer_occupancy;
//  - pops on get_tx_packet_data.

---
 rtl/usb_data_buffer.sv | 132 +++++++++++++
 tb/tb_usb_data_buffer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/usb_data_buffer.sv
// Shared 64-byte show-ahead FIFO between the AHB slave and the USB TX/RX datapaths.
// Optional macro USB_DATA_BUFFER_ERR_EN adds a sticky buffer_error output for ignored push/pop.
module usb_data_buffer #(
  parameter int ADDR_BITS  = 6,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  store_tx_data,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  get_tx_packet_data,
  output logic [DATA_WIDTH-1:0] tx_packet_data,
  input  logic                  store_rx_packet_data,
  input  logic [DATA_WIDTH-1:0] rx_packet_data,
  input  logic                  get_rx_data,
  output logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  clear,
  input  logic                  flush,
  output logic [ADDR_BITS:0]    buffer_occupancy
`ifdef USB_DATA_BUFFER_ERR_EN
  ,
  output logic                  buffer_error
`endif
);

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam logic [ADDR_BITS:0] FULL_COUNT = {1'b1, {ADDR_BITS{1'b0}}};

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_BITS-1:0]  wr_ptr_q, wr_ptr_d;
  logic [ADDR_BITS-1:0]  rd_ptr_q, rd_ptr_d;
  logic [ADDR_BITS:0]    count_q, count_d;
  logic [DATA_WIDTH-1:0] wdata_s;
  logic                  push_s, pop_s, clr_s, full_s, empty_s;
  logic                  do_push_s, do_pop_s;

  // Request decode; rx writer has priority over the AHB writer.
  always_comb begin
    push_s    = store_rx_packet_data | store_tx_data;
    pop_s     = get_tx_packet_data | get_rx_data;
    clr_s     = clear | flush;
    wdata_s   = store_rx_packet_data ? rx_packet_data : tx_data;
    full_s    = (count_q == FULL_COUNT);
    empty_s   = (count_q == {(ADDR_BITS+1){1'b0}});
    do_push_s = push_s & ~full_s & ~clr_s;
    do_pop_s  = pop_s & ~empty_s & ~clr_s;
  end

  // Pointer and occupancy next-state; clear/flush overrides any transfer.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr_s) begin
      wr_ptr_d = {ADDR_BITS{1'b0}};
      rd_ptr_d = {ADDR_BITS{1'b0}};
      count_d  = {(ADDR_BITS+1){1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_d = wr_ptr_q + ADDR_BITS'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (do_pop_s) begin
        rd_ptr_d = rd_ptr_q + ADDR_BITS'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_d = count_q + (ADDR_BITS+1)'(1);
        2'b01:   count_d = count_q - (ADDR_BITS+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr_q <= {ADDR_BITS{1'b0}};
      rd_ptr_q <= {ADDR_BITS{1'b0}};
      count_q  <= {(ADDR_BITS+1){1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents survive reset and clear.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= wdata_s;
    end
  end

  // Show-ahead head byte, forced to zero while empty.
  always_comb begin
    if (empty_s) begin
      tx_packet_data = {DATA_WIDTH{1'b0}};
    end else begin
      tx_packet_data = mem_q[rd_ptr_q];
    end
    rx_data          = tx_packet_data;
    buffer_occupancy = count_q;
  end

`ifdef USB_DATA_BUFFER_ERR_EN
  logic err_q, err_d;

  // Sticky error on an ignored push (full) or ignored pop (empty).
  always_comb begin
    if (clr_s) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q | (push_s & full_s) | (pop_s & empty_s);
    end
  end

  // Error flag register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign buffer_error = err_q;
`endif

endmodule

// File: tb/tb_usb_data_buffer.sv
// Scoreboard bench for usb_data_buffer: a queue model tracks expected bytes and occupancy.
module tb_usb_data_buffer;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       store_tx_data, store_rx_packet_data;
  logic [7:0] tx_data, rx_packet_data;
  logic       get_tx_packet_data, get_rx_data;
  logic       clear, flush;
  logic [7:0] tx_packet_data, rx_data;
  logic [6:0] buffer_occupancy;
`ifdef USB_DATA_BUFFER_ERR_EN
  logic       buffer_error;
  logic       exp_err;
`endif

  int         chk_cnt  = 0;
  int         pass_cnt = 0;
  logic [7:0] sb_q[$];

  usb_data_buffer dut (
    .clk                  (clk),
    .n_rst                (n_rst),
    .store_tx_data        (store_tx_data),
    .tx_data              (tx_data),
    .get_tx_packet_data   (get_tx_packet_data),
    .tx_packet_data       (tx_packet_data),
    .store_rx_packet_data (store_rx_packet_data),
    .rx_packet_data       (rx_packet_data),
    .get_rx_data          (get_rx_data),
    .rx_data              (rx_data),
    .clear                (clear),
    .flush                (flush),
    .buffer_occupancy     (buffer_occupancy)
`ifdef USB_DATA_BUFFER_ERR_EN
    ,
    .buffer_error         (buffer_error)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    store_tx_data        = 1'b0;
    store_rx_packet_data = 1'b0;
    tx_data              = 8'h00;
    rx_packet_data       = 8'h00;
    get_tx_packet_data   = 1'b0;
    get_rx_data          = 1'b0;
    clear                = 1'b0;
    flush                = 1'b0;
  endtask

  // One clock of stimulus, called at a negedge; updates the scoreboard and checks after the edge.
  task automatic step(input logic s_tx, input logic [7:0] d_tx, input logic s_rx, input logic [7:0] d_rx,
                      input logic g_tx, input logic g_rx, input logic clr, input logic fl,
                      input string tag);
    int         sz;
    logic [7:0] exp_head;
    store_tx_data        = s_tx;
    tx_data              = d_tx;
    store_rx_packet_data = s_rx;
    rx_packet_data       = d_rx;
    get_tx_packet_data   = g_tx;
    get_rx_data          = g_rx;
    clear                = clr;
    flush                = fl;
    sz = sb_q.size();
`ifdef USB_DATA_BUFFER_ERR_EN
    if (clr || fl) exp_err = 1'b0;
    else if (((s_tx || s_rx) && sz == 64) || ((g_tx || g_rx) && sz == 0)) exp_err = 1'b1;
`endif
    if (clr || fl) begin
      sb_q.delete();
    end else begin
      if ((g_tx || g_rx) && sz > 0) void'(sb_q.pop_front());
      if ((s_tx || s_rx) && sz < 64) sb_q.push_back(s_rx ? d_rx : d_tx);
    end
    @(posedge clk);
    #1;
    idle_inputs();
    exp_head = (sb_q.size() > 0) ? sb_q[0] : 8'h00;
    check_val({tag, "_occ"}, 32'(buffer_occupancy), 32'(sb_q.size()));
    check_val({tag, "_txhead"}, 32'(tx_packet_data), 32'(exp_head));
    check_val({tag, "_rxhead"}, 32'(rx_data), 32'(exp_head));
`ifdef USB_DATA_BUFFER_ERR_EN
    check_val({tag, "_err"}, 32'(buffer_error), 32'(exp_err));
`endif
    @(negedge clk);
  endtask

  task automatic push_tx(input logic [7:0] d, input string tag);
    step(1'b1, d, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, tag);
  endtask

  task automatic pop_tx(input string tag);
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, tag);
  endtask

  initial begin
    idle_inputs();
    n_rst = 1'b0;
`ifdef USB_DATA_BUFFER_ERR_EN
    exp_err = 1'b0;
`endif
    #2;
    check_val("rst_occ", 32'(buffer_occupancy), 32'd0);
    check_val("rst_tx", 32'(tx_packet_data), 32'h00);
    check_val("rst_rx", 32'(rx_data), 32'h00);
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);

    // Reset mid-fill
    for (int i = 0; i < 5; i++) push_tx(8'h10 + 8'(i), "fill5");
    #2;
    n_rst = 1'b0;
    #1;
    check_val("midrst_occ", 32'(buffer_occupancy), 32'd0);
    check_val("midrst_tx", 32'(tx_packet_data), 32'h00);
    sb_q.delete();
`ifdef USB_DATA_BUFFER_ERR_EN
    exp_err = 1'b0;
`endif
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);

    // Ordering
    for (int i = 0; i < 4; i++) push_tx(8'hA1 + 8'(i), "ord_push");
    check_val("ord_occ4", 32'(buffer_occupancy), 32'd4);
    check_val("ord_head_a1", 32'(tx_packet_data), 32'hA1);
    for (int i = 0; i < 4; i++) pop_tx("ord_pop");
    check_val("ord_empty", 32'(buffer_occupancy), 32'd0);

    // Pop on empty, then clear
    pop_tx("empty_pop");
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, "clr_err");

    // Full and wrap
    for (int i = 0; i < 64; i++) push_tx(8'(i) ^ 8'h80, "full_push");
    check_val("full_occ64", 32'(buffer_occupancy), 32'd64);
    push_tx(8'hEE, "push65");
    pop_tx("full_pop1");
    push_tx(8'h5C, "wrap_push");
    for (int i = 0; i < 63; i++) pop_tx("drain");
    check_val("wrap_last_5c", 32'(tx_packet_data), 32'h5C);
    pop_tx("drain_last");
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, "clr2");

    // Simultaneous push and pop at occupancy 10
    for (int i = 0; i < 10; i++) push_tx(8'h20 + 8'(i), "sim_fill");
    for (int i = 0; i < 20; i++)
      step(1'b1, 8'h40 + 8'(i), 1'b0, 8'h00, 1'b1, (i % 3) == 0, 1'b0, 1'b0, "sim_pp");
    check_val("sim_occ10", 32'(buffer_occupancy), 32'd10);

    // Dual writer into an empty buffer
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, "clr3");
    step(1'b1, 8'h77, 1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 1'b0, "dual");
    check_val("dual_head33", 32'(tx_packet_data), 32'h33);
    for (int i = 0; i < 3; i++)
      step(1'b0, 8'h00, 1'b1, 8'hB0 + 8'(i), 1'b0, 1'b1, 1'b0, 1'b0, "rx_pp");

    // Flush priority over push at occupancy 12
    for (int i = 0; i < 11; i++) push_tx(8'hC0 + 8'(i), "fl_fill");
    check_val("fl_occ12", 32'(buffer_occupancy), 32'd12);
    step(1'b1, 8'hDD, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, "flush_push");
    check_val("fl_occ0", 32'(buffer_occupancy), 32'd0);
    pop_tx("empty_pop2");
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, "clr4");
    push_tx(8'h99, "post_clr");
    pop_tx("post_clr_pop");

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
